// File: rtl/fetch_loader.sv
// Program loader and instruction fetch sequencer. Assembles byte-serial program
// images into 16-bit words written to instruction memory, then drives the
// program counter during execution with stall, branch and halt control.
module fetch_loader #(
  parameter int unsigned PC_BITS = 6
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [7:0]         load_data,
  input  logic               load_done,
  input  logic               run,
  input  logic               halt_req,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_BITS-1:0] branch_target,
  output logic [PC_BITS-1:0] pc,
  output logic               we_insmem,
  output logic [15:0]        instruction_in,
  output logic               load_ready,
  output logic               running,
  output logic               instr_valid,
  output logic               load_overflow
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadHi,
    StLoadLo,
    StWrite,
    StRun,
    StHalt
  } state_e;

  // Highest word address; writing here fills the memory.
  localparam logic [PC_BITS-1:0] PcLast = {{(PC_BITS-1){1'b1}}, 1'b0};
  localparam logic [PC_BITS-1:0] PcStep = PC_BITS'(2);

  state_e             state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [15:0]        instr_q, instr_d;
  logic               ovf_q, ovf_d;
  logic               we_q, ready_q, running_q, valid_q;
  logic               byte_xfer;

  assign byte_xfer = load_valid && ready_q;

  // Next-state, program counter and word assembly.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoadHi;
          pc_d    = '0;
          ovf_d   = 1'b0;
        end else if (run) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StLoadHi: begin
        // End of image wins; a byte offered alongside it is dropped.
        if (load_done) begin
          state_d = StIdle;
        end else if (byte_xfer) begin
          instr_d[15:8] = load_data;
          state_d       = StLoadLo;
        end
      end
      StLoadLo: begin
        if (byte_xfer) begin
          instr_d[7:0] = load_data;
          state_d      = StWrite;
        end
      end
      StWrite: begin
        if (pc_q == PcLast) begin
          pc_d    = '0;
          ovf_d   = 1'b1;
          state_d = StIdle;
        end else begin
          pc_d    = pc_q + PcStep;
          state_d = StLoadHi;
        end
      end
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch_taken) begin
          pc_d = {branch_target[PC_BITS-1:1], 1'b0};
        end else begin
          pc_d = pc_q + PcStep;
        end
      end
      StHalt: begin
        if (load_start) begin
          state_d = StLoadHi;
          pc_d    = '0;
        end else if (run) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; flags are decoded from the next state so
  // they line up with the cycle spent in that state.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      instr_q   <= '0;
      ovf_q     <= 1'b0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      running_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ovf_q     <= ovf_d;
      we_q      <= (state_d == StWrite);
      ready_q   <= (state_d == StLoadHi) || (state_d == StLoadLo);
      running_q <= (state_d == StRun);
      valid_q   <= (state_d == StRun) && !stall;
    end
  end

  assign pc             = pc_q;
  assign we_insmem      = we_q;
  assign instruction_in = instr_q;
  assign load_ready     = ready_q;
  assign running        = running_q;
  assign instr_valid    = valid_q;
  assign load_overflow  = ovf_q;

endmodule

// File: tb/tb_fetch_loader.sv
// Scoreboard bench for fetch_loader: stimulus tasks push expected memory writes
// and expected fetch addresses; a negedge monitor pops and compares them.
module tb_fetch_loader;

  localparam int PB    = 6;
  localparam int MaxPc = (1 << PB) - 2;

  logic          clka, reset;
  logic          load_start, load_valid, load_done, run, halt_req, stall, branch_taken;
  logic [7:0]    load_data;
  logic [PB-1:0] branch_target, pc;
  logic          we_insmem, load_ready, running, instr_valid, load_overflow;
  logic [15:0]   instruction_in;

  fetch_loader #(.PC_BITS(PB)) dut (
    .clka          (clka),
    .reset         (reset),
    .load_start    (load_start),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_done     (load_done),
    .run           (run),
    .halt_req      (halt_req),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .we_insmem     (we_insmem),
    .instruction_in(instruction_in),
    .load_ready    (load_ready),
    .running       (running),
    .instr_valid   (instr_valid),
    .load_overflow (load_overflow)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  int n_checks = 0;
  int n_fail   = 0;

  int         wq[$];   // expected {addr, word} per memory write
  int         vq[$];   // expected pc per consumed instruction
  logic [7:0] img[$];

  // Behavioural execution model: mode and program counter only.
  typedef enum int {MIdle, MRun, MHalt} mode_e;
  mode_e mode = MIdle;
  int    mpc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // Monitor: every write and every consumed instruction must match the queues.
  always @(negedge clka) begin
    if (!reset) begin
      chk("pc_bit0", {31'd0, pc[0]}, 32'd0);
      if (we_insmem) begin
        if (wq.size() == 0) chk("unexpected_write", {16'd0, instruction_in}, 32'hFFFF_FFFF);
        else chk("write", {10'd0, pc, instruction_in}, wq.pop_front());
      end
      if (instr_valid) begin
        if (vq.size() == 0) chk("unexpected_fetch", {26'd0, pc}, 32'hFFFF_FFFF);
        else chk("fetch_pc", {26'd0, pc}, vq.pop_front());
      end
    end
  end

  // Loads img[] from IDLE or HALT; ends with load_done unless memory fills.
  task automatic load_image(input bit done_with_valid);
    int         addr;
    int         gaps;
    bit         ovf;
    logic [7:0] hi;
    addr = 0;
    ovf  = 1'b0;
    hi   = 8'h00;
    load_start = 1'b1;
    run        = 1'($urandom_range(0, 1));   // load_start must win
    step();
    load_start = 1'b0;
    run        = 1'b0;
    chk("start_ready", {31'd0, load_ready}, 32'd1);
    chk("start_pc", {26'd0, pc}, 32'd0);
    chk("start_running", {31'd0, running}, 32'd0);
    for (int i = 0; i < img.size(); i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        load_done  = (i % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        chk("gap_ready", {31'd0, load_ready}, 32'd1);
        step();
      end
      load_done  = (i % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      load_valid = 1'b1;
      load_data  = img[i];
      chk("byte_ready", {31'd0, load_ready}, 32'd1);
      step();
      load_done = 1'b0;
      if (i % 2 == 0) begin
        hi = img[i];
      end else begin
        wq.push_back((addr << 16) | {16'd0, hi, img[i]});
        // Write cycle: offered bytes and load_done are ignored.
        load_valid = 1'($urandom_range(0, 1));
        load_data  = 8'($urandom);
        load_done  = 1'($urandom_range(0, 1));
        chk("write_ready", {31'd0, load_ready}, 32'd0);
        step();
        load_valid = 1'b0;
        load_done  = 1'b0;
        if (addr == MaxPc) begin
          ovf  = 1'b1;
          addr = 0;
          break;
        end
        addr += 2;
      end
    end
    if (!ovf) begin
      load_done  = 1'b1;
      load_valid = done_with_valid;
      load_data  = 8'hEE;
      step();
      load_done  = 1'b0;
      load_valid = 1'b0;
    end
    step();
    chk("end_ready", {31'd0, load_ready}, 32'd0);
    chk("end_overflow", {31'd0, load_overflow}, {31'd0, ovf});
    chk("end_pc", {26'd0, pc}, addr);
    chk("end_we", {31'd0, we_insmem}, 32'd0);
    chk("write_queue_drained", wq.size(), 32'd0);
    mode = MIdle;
    mpc  = addr;
  endtask

  // One execution-control edge, with the model advanced alongside.
  task automatic run_step(input bit r, input bit h, input bit s, input bit b,
                          input logic [PB-1:0] t);
    run = r; halt_req = h; stall = s; branch_taken = b; branch_target = t;
    case (mode)
      MIdle: if (r) begin mode = MRun; mpc = 0; if (!s) vq.push_back(mpc); end
      MHalt: if (r) begin mode = MRun; if (!s) vq.push_back(mpc); end
      default: begin
        if (h) mode = MHalt;
        else if (!s) begin
          mpc = b ? (int'(t) & ~1) : ((mpc + 2) % (1 << PB));
          vq.push_back(mpc);
        end
      end
    endcase
    step();
    run = 1'b0; halt_req = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    chk("running", {31'd0, running}, {31'd0, mode == MRun});
    chk("run_pc", {26'd0, pc}, mpc);
  endtask

  initial begin
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    load_done = 1'b0; run = 1'b0; halt_req = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_pc", {26'd0, pc}, 32'd0);
    chk("rst_we", {31'd0, we_insmem}, 32'd0);
    chk("rst_instr", {16'd0, instruction_in}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_overflow", {31'd0, load_overflow}, 32'd0);
    @(posedge clka);
    #1 reset = 1'b0;

    // Two-word image.
    img = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    load_image(1'b0);
    // load_done with a simultaneous byte: byte dropped.
    img = '{8'h01, 8'h02};
    load_image(1'b1);
    // Full memory: 64 bytes -> 32 writes, overflow, pc wraps.
    img = {};
    for (int i = 0; i < 64; i++) img.push_back(8'($urandom));
    load_image(1'b0);
    // A fresh load clears overflow.
    img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h5A, 8'hA5};
    load_image(1'b0);

    // Reset in the middle of LOAD_LO: partial word abandoned.
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h55; step(); load_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_we", {31'd0, we_insmem}, 32'd0);
    chk("midrst_ready", {31'd0, load_ready}, 32'd0);
    chk("midrst_pc", {26'd0, pc}, 32'd0);
    chk("midrst_instr", {16'd0, instruction_in}, 32'd0);
    @(posedge clka);
    #1 reset = 1'b0;
    step();
    chk("midrst_no_write", wq.size(), 32'd0);
    mode = MIdle; mpc = 0;

    // run, three free cycles, branch to 0x15 -> 0,2,4,6,0x14.
    run_step(1, 0, 0, 0, '0);
    repeat (3) run_step(0, 0, 0, 0, '0);
    run_step(0, 0, 0, 1, 6'h15);
    chk("branch_odd", {26'd0, pc}, 32'h14);
    // At pc=8: stall, then stall+halt -> HALT at 8; resume.
    run_step(0, 0, 0, 1, 6'd8);
    run_step(0, 0, 1, 0, '0);
    chk("stall_valid", {31'd0, instr_valid}, 32'd0);
    run_step(0, 1, 1, 0, '0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_pc", {26'd0, pc}, 32'd8);
    run_step(1, 0, 0, 0, '0);
    run_step(0, 0, 0, 0, '0);
    chk("resume_pc", {26'd0, pc}, 32'd10);

    // Randomized execution control.
    for (int i = 0; i < 300; i++) begin
      run_step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               PB'($urandom));
    end
    if (mode == MRun) run_step(0, 1, 0, 0, '0);
    // Load from HALT (or IDLE).
    img = '{8'h77, 8'h88};
    load_image(1'b0);

    step();
    chk("fetch_queue_drained", vq.size(), 32'd0);
    chk("write_queue_final", wq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
